// File: rtl/shifter_seq64.sv
// Sequential 64-bit shifter (SRL/SLL/SRA/ROR) that reuses one 32-bit funnel
// shifter over two cycles: the low result word first, then the high word.
module shifter_seq64 #(
  parameter int ENABLE_SRA = 1,
  parameter int ENABLE_ROR = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [63:0] in_data,
  input  logic [5:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [63:0] x_q;
  logic [5:0]  s_q;
  logic [63:0] data_q;
  logic [1:0]  op_eff;

  logic        rev;
  logic [31:0] wh, wl, fill1, fill2;
  logic [31:0] f_h, f_l;
  logic [31:0] fun_h, fun_l, fun_y;
  logic [63:0] fun_cat;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Disabled ops are folded to SRL at accept so the datapath never sees them.
  always_comb begin
    op_eff = in_op;
    if (in_op == OP_SRA && ENABLE_SRA == 0) op_eff = OP_SRL;
    if (in_op == OP_ROR && ENABLE_ROR == 0) op_eff = OP_SRL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LO;
      LO:      state_next = HI;
      HI:      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // SLL swaps the operand words here; the funnel's reflection then turns them
  // into the words of the bit-reflected operand, so one right-shift schedule
  // serves all four ops.
  always_comb begin
    rev   = (op_q == OP_SLL);
    wh    = rev ? x_q[31:0]  : x_q[63:32];
    wl    = rev ? x_q[63:32] : x_q[31:0];
    fill1 = (op_q == OP_SRA) ? {32{x_q[63]}} : 32'h0;
    fill2 = fill1;
    if (op_q == OP_ROR) begin
      fill1 = wl;
      fill2 = wh;
    end
    f_h = wh;
    f_l = wl;
    if (state == HI) begin
      if (s_q[5]) begin
        f_h = fill2;
        f_l = fill1;
      end else begin
        f_h = fill1;
        f_l = wh;
      end
    end else if (s_q[5]) begin
      f_h = fill1;
      f_l = wh;
    end
  end

  always_comb begin
    fun_h   = rev ? rev32(f_h) : f_h;
    fun_l   = rev ? rev32(f_l) : f_l;
    fun_cat = {fun_h, fun_l} >> s_q[4:0];
    fun_y   = rev ? rev32(fun_cat[31:0]) : fun_cat[31:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= 2'b00;
      x_q    <= 64'h0;
      s_q    <= 6'h0;
      data_q <= 64'h0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op_eff;
          x_q  <= in_data;
          s_q  <= in_shamt;
        end
        LO: if (rev) data_q[63:32] <= fun_y;
            else     data_q[31:0]  <= fun_y;
        HI: if (rev) data_q[31:0]  <= fun_y;
            else     data_q[63:32] <= fun_y;
        default: ;
      endcase
    end
  end

  assign out_data = data_q;

endmodule
